arbitro_contadores: RTL and testbench

ARBITRO_CONTADORES -- requirements
Module: arbitro_contadores

---
 rtl/arbitro_contadores_if.sv | 33 +++
 rtl/arbitro_contadores.sv | 136 +++++++++++++
 tb/tb_arbitro_contadores.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arbitro_contadores_if.sv
// Bus bundle between the counter arbiter and its environment: adder requests,
// command pulses, the external counter memory and the dump stream.
`timescale 1ns/1ps
interface arbitro_contadores_if #(
  parameter int NREQ = 3,
  parameter int AW   = 2,
  parameter int DW   = 32
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] delta;
  logic [NREQ-1:0]   gnt;
  logic              clear_start;
  logic              read_start;
  logic              busy;
  logic [AW-1:0]     mem_dir;
  logic              mem_LE;
  logic [DW-1:0]     mem_dato_out;
  logic [DW-1:0]     mem_dato_in;
  logic              rd_valid;
  logic [AW-1:0]     rd_dir;
  logic [DW-1:0]     rd_data;

  // Environment side: adders, command source and the counter memory.
  modport master (
    output req, delta, clear_start, read_start, mem_dato_in,
    input  gnt, busy, mem_dir, mem_LE, mem_dato_out, rd_valid, rd_dir, rd_data
  );

  modport slave (
    input  req, delta, clear_start, read_start, mem_dato_in,
    output gnt, busy, mem_dir, mem_LE, mem_dato_out, rd_valid, rd_dir, rd_data
  );
endinterface

// File: rtl/arbitro_contadores.sv
// Round-robin arbiter doing read-modify-write increments of NREQ counters in an
// external memory, plus clear and dump commands. Define CONTADOR_SATURA_EN to saturate sums.
`timescale 1ns/1ps
module arbitro_contadores #(
  parameter int NREQ = 3,
  parameter int AW   = 2,
  parameter int DW   = 32
) (
  input  logic                  clk,
  input  logic                  reset_L,
  arbitro_contadores_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, RD, WR, DUMP} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NREQ - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;     // selected requester, or sweep address in CLEAR/DUMP
  logic [AW-1:0] last_q, last_d;   // last granted requester
  logic [DW-1:0] data_q, data_d;
  logic [7:0]    delta_q, delta_d;

  logic          rr_found;
  logic [AW-1:0] rr_sel;
  logic [DW:0]   wr_sum;
  logic [DW-1:0] wr_data;

  // Round-robin search from last_q+1; scanning downward lets the nearest hit win.
  always_comb begin
    int cand;
    rr_found = 1'b0;
    rr_sel   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = (int'(last_q) + k) % NREQ;
      if (bus.req[cand]) begin
        rr_found = 1'b1;
        rr_sel   = AW'(cand);
      end
    end
  end

  assign wr_sum = {1'b0, data_q} + (DW+1)'(delta_q);

`ifdef CONTADOR_SATURA_EN
  assign wr_data = wr_sum[DW] ? {DW{1'b1}} : wr_sum[DW-1:0];
`else
  assign wr_data = wr_sum[DW-1:0];
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d          = state_q;
    idx_d            = idx_q;
    last_d           = last_q;
    data_d           = data_q;
    delta_d          = delta_q;
    bus.busy         = (state_q != IDLE);
    bus.mem_LE       = 1'b1;
    bus.mem_dir      = '0;
    bus.mem_dato_out = '0;
    bus.gnt          = '0;
    bus.rd_valid     = 1'b0;
    bus.rd_dir       = '0;
    bus.rd_data      = '0;

    case (state_q)
      IDLE: begin
        if (bus.clear_start) begin
          state_d = CLEAR;
          idx_d   = '0;
        end else if (bus.read_start) begin
          state_d = DUMP;
          idx_d   = '0;
        end else if (rr_found) begin
          state_d = RD;
          idx_d   = rr_sel;
        end
      end

      CLEAR: begin
        bus.mem_LE  = 1'b0;
        bus.mem_dir = idx_q;
        if (idx_q == LAST_ADDR) state_d = IDLE;
        else                    idx_d   = idx_q + 1'b1;
      end

      RD: begin
        bus.mem_dir = idx_q;
        // Delta is latched here so a requester dropping req early still gets a consistent sum.
        data_d  = bus.mem_dato_in;
        delta_d = bus.delta[8*idx_q +: 8];
        state_d = WR;
      end

      WR: begin
        bus.mem_LE       = 1'b0;
        bus.mem_dir      = idx_q;
        bus.mem_dato_out = wr_data;
        bus.gnt          = NREQ'(1) << idx_q;
        last_d           = idx_q;
        state_d          = IDLE;
      end

      DUMP: begin
        bus.mem_dir  = idx_q;
        bus.rd_valid = 1'b1;
        bus.rd_dir   = idx_q;
        bus.rd_data  = bus.mem_dato_in;
        if (idx_q == LAST_ADDR) state_d = IDLE;
        else                    idx_d   = idx_q + 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  // Reset pointer at NREQ-1 makes requester 0 the first winner.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= LAST_ADDR;
      data_q  <= '0;
      delta_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      data_q  <= data_d;
      delta_q <= delta_d;
    end
  end

endmodule

// File: tb/tb_arbitro_contadores.sv
// Self-checking bench for arbitro_contadores: behavioural counter model feeds a
// scoreboard queue; a negedge monitor pops and compares every write, grant and dump word.
`timescale 1ns/1ps
module tb_arbitro_contadores;
  localparam int NREQ = 3;
  localparam int AW   = 2;
  localparam int DW   = 32;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk = ~clk;

  arbitro_contadores_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  arbitro_contadores #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  // External counter memory with a backdoor port used only while the DUT is idle.
  logic [DW-1:0] mem [4];
  logic          bd_en = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_en)            mem[bd_addr]     <= bd_data;
    else if (!bus.mem_LE) mem[bus.mem_dir] <= bus.mem_dato_out;
  end
  assign bus.mem_dato_in = mem[bus.mem_dir];

  typedef enum int {EV_CLR, EV_GNT, EV_DUMP} ev_kind_t;
  typedef struct {
    ev_kind_t      kind;
    int            dir;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] model_cnt [NREQ];
  int            rr_last = NREQ - 1;
  int            cyc = 0;
  bit            gap_mode = 1'b0;
  int            gap_prev = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] model_add(input logic [DW-1:0] a, input logic [7:0] d);
    longint unsigned s;
    s = longint'(a) + longint'(d);
`ifdef CONTADOR_SATURA_EN
    if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
`endif
    return DW'(s);
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] m);
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (rr_last + k) % NREQ;
      if (m[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_grant(input int i, input logic [7:0] d);
    exp_t e;
    model_cnt[i] = model_add(model_cnt[i], d);
    e.kind = EV_GNT; e.dir = i; e.data = model_cnt[i];
    exp_q.push_back(e);
    rr_last = i;
  endtask

  task automatic model_clear();
    exp_t e;
    for (int i = 0; i < NREQ; i++) begin
      model_cnt[i] = '0;
      e.kind = EV_CLR; e.dir = i; e.data = '0;
      exp_q.push_back(e);
    end
  endtask

  task automatic model_dump();
    exp_t e;
    for (int i = 0; i < NREQ; i++) begin
      e.kind = EV_DUMP; e.dir = i; e.data = model_cnt[i];
      exp_q.push_back(e);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic pop_check(input string name, input ev_kind_t kind, input int dir, input logic [DW-1:0] data);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected: got dir %0d data %0h, expected no event (t=%0t)", name, dir, data, $time);
    end else begin
      e = exp_q.pop_front();
      check({name, "_kind"}, 64'(kind), 64'(e.kind));
      check({name, "_dir"},  64'(dir),  64'(e.dir));
      check({name, "_data"}, 64'(data), 64'(e.data));
    end
  endtask

  always @(negedge clk) begin
    int gi;
    if (reset_L) begin
      if (bus.gnt != '0) begin
        gi = -1;
        for (int k = 0; k < NREQ; k++) if (bus.gnt[k]) gi = k;
        check("gnt_onehot", 64'($countones(bus.gnt)), 64'd1);
        check("gnt_write_mode", 64'(bus.mem_LE), 64'd0);
        check("gnt_dir_match", 64'(bus.mem_dir), 64'(gi));
        pop_check("grant", EV_GNT, gi, bus.mem_dato_out);
        if (gap_mode) begin
          if (gap_prev >= 0) check("grant_spacing", 64'(cyc - gap_prev), 64'd3);
          gap_prev = cyc;
        end
      end else if (!bus.mem_LE) begin
        pop_check("clear", EV_CLR, int'(bus.mem_dir), bus.mem_dato_out);
      end
      if (bus.rd_valid) begin
        check("dump_read_mode", 64'(bus.mem_LE), 64'd1);
        check("dump_dir_match", 64'(bus.rd_dir), 64'(bus.mem_dir));
        pop_check("dump", EV_DUMP, int'(bus.rd_dir), bus.rd_data);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic bd_write(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    bd_en = 1'b1; bd_addr = AW'(a); bd_data = d;
    @(negedge clk);
    bd_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 100);
    check({tag, "_idle"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic do_clear(input bit count_busy);
    int n = 0;
    @(negedge clk);
    bus.clear_start = 1'b1;
    model_clear();
    @(negedge clk);
    bus.clear_start = 1'b0;
    if (count_busy) begin
      while (bus.busy && n < 20) begin
        n++;
        @(negedge clk);
      end
      check("clear_busy_cycles", 64'(n), 64'(NREQ));
    end
    wait_idle("clear");
  endtask

  task automatic do_dump();
    @(negedge clk);
    bus.read_start = 1'b1;
    model_dump();
    @(negedge clk);
    bus.read_start = 1'b0;
    wait_idle("dump");
  endtask

  // Each requester drops req on its grant; optionally pokes commands while busy.
  task automatic run_reqs(input logic [NREQ-1:0] mask, input bit poke_busy);
    logic [NREQ-1:0] m;
    int n = 0;
    m = mask;
    while (m != '0) begin
      int i;
      i = rr_pick(m);
      model_grant(i, bus.delta[8*i +: 8]);
      m[i] = 1'b0;
    end
    @(negedge clk);
    bus.req = mask;
    while ((bus.req != '0 || bus.busy) && n < 200) begin
      @(negedge clk);
      n++;
      bus.read_start  = 1'b0;
      bus.clear_start = 1'b0;
      if ((bus.gnt & bus.req) != '0) bus.req = bus.req & ~bus.gnt;
      else if (poke_busy && bus.busy && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 0) bus.read_start  = 1'b1;
        else                           bus.clear_start = 1'b1;
      end
    end
    check("req_phase_done", 64'(n < 200), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int n;
    logic [7:0] d;
    bus.req = '0; bus.delta = '0; bus.clear_start = 1'b0; bus.read_start = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_busy",     64'(bus.busy),         64'd0);
    check("rst_mem_LE",   64'(bus.mem_LE),       64'd1);
    check("rst_mem_dir",  64'(bus.mem_dir),      64'd0);
    check("rst_dato_out", 64'(bus.mem_dato_out), 64'd0);
    check("rst_gnt",      64'(bus.gnt),          64'd0);
    check("rst_rd_valid", 64'(bus.rd_valid),     64'd0);
    check("rst_rd_dir",   64'(bus.rd_dir),       64'd0);
    check("rst_rd_data",  64'(bus.rd_data),      64'd0);

    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] v;
      v = $urandom;
      bd_write(i, v);
      if (i < NREQ) model_cnt[i] = v;
    end
    @(negedge clk);
    reset_L = 1'b1;

    do_dump();
    do_clear(1'b1);

    // All requests held continuously: expected order 0,1,2,0 at 3-cycle spacing
    for (int i = 0; i < NREQ; i++) bus.delta[8*i +: 8] = 8'($urandom_range(1, 255));
    for (int k = 0; k < 4; k++) begin
      int i;
      i = rr_pick('1);
      model_grant(i, bus.delta[8*i +: 8]);
    end
    gap_mode = 1'b1; gap_prev = -1;
    @(negedge clk);
    bus.req = '1;
    g = 0; n = 0;
    while (g < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.gnt != '0) g++;
      if (g == 4) bus.req = '0;
    end
    check("hold_all_grants", 64'(g), 64'd4);
    wait_idle("hold_all");
    gap_mode = 1'b0;

    // Memory[1]=5 plus delta 7, grant two cycles after acceptance
    bd_write(1, 32'd5);
    model_cnt[1] = 32'd5;
    bus.delta[15:8] = 8'd7;
    model_grant(1, 8'd7);
    @(negedge clk);
    bus.req = 3'b010;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.gnt == '0 && n < 10);
    bus.req = '0;
    check("grant_latency", 64'(n), 64'd2);
    wait_idle("single");
    check("mem1_incremented", 64'(mem[1]), 64'd12);

    // clear_start and req[0] in the same idle cycle: clear wins, request follows
    d = 8'($urandom_range(1, 255));
    bus.delta[7:0] = d;
    model_clear();
    model_grant(0, d);
    @(negedge clk);
    bus.clear_start = 1'b1;
    bus.req = 3'b001;
    @(negedge clk);
    bus.clear_start = 1'b0;
    n = 0;
    while (bus.gnt[0] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus.req = '0;
    check("clear_then_req_grant", 64'(bus.gnt), 64'd1);
    wait_idle("clear_req");

    // Overflow boundary on counter 2
    bd_write(2, 32'hFFFF_FFFE);
    model_cnt[2] = 32'hFFFF_FFFE;
    bus.delta[23:16] = 8'd5;
    run_reqs(3'b100, 1'b0);
`ifdef CONTADOR_SATURA_EN
    check("overflow_result", 64'(mem[2]), 64'hFFFF_FFFF);
`else
    check("overflow_result", 64'(mem[2]), 64'h0000_0003);
`endif

    // Reset during WR: write dropped, pointer back to NREQ-1
    bus.delta[23:16] = 8'($urandom_range(1, 255));
    @(negedge clk);
    bus.req = 3'b100;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_L = 1'b0;
    bus.req = '0;
    #1;
    check("abort_gnt",    64'(bus.gnt),    64'd0);
    check("abort_mem_LE", 64'(bus.mem_LE), 64'd1);
    check("abort_busy",   64'(bus.busy),   64'd0);
    rr_last = NREQ - 1;
    @(negedge clk);
    @(negedge clk);
    reset_L = 1'b1;
    check("abort_mem2_kept", 64'(mem[2]), 64'(model_cnt[2]));
    do_dump();

    // Randomised mix of request bursts, dumps and clears
    repeat (30) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 7) begin
        for (int i = 0; i < NREQ; i++) bus.delta[8*i +: 8] = 8'($urandom);
        run_reqs(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 1'b1);
      end else if (op < 9) begin
        do_dump();
      end else begin
        do_clear(1'b0);
      end
    end
    do_dump();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
